alu_cmd_sequencer: RTL and testbench

Command-side driver for the 8-bit ALU. Accepts ALU commands on a valid/ready handshake and keeps a 4-entry × 8-bit register file. For each command it presents registered operands and opcode to the ALU, samples the ALU result, and writes it back. A command can repeat its operation up to 15 times, which supports shift loops and count-downs. The block sits between the instruction decode stage and the combinational ALU, and is the only driver of the ALU's OP/INPUTA/INPUTB inputs.

---
 rtl/alu_cmd_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer_pkg: opcode encoding (op_mne) shared with the 8-bit ALU.
// Opcodes outside this list are still issued unchanged; the ALU answers them with 0.
package alu_cmd_sequencer_pkg;
  localparam logic [3:0] kCLEAR          = 4'd0;
  localparam logic [3:0] kADD            = 4'd1;
  localparam logic [3:0] kSUB            = 4'd2;
  localparam logic [3:0] kINC_INPUTA     = 4'd3;
  localparam logic [3:0] kDEC_INPUTA     = 4'd4;
  localparam logic [3:0] kSHIFT_LEFT     = 4'd5;
  localparam logic [3:0] kSHIFT_RIGHT    = 4'd6;
  localparam logic [3:0] kPASS_INPUTA    = 4'd7;
  localparam logic [3:0] kAND            = 4'd8;
  localparam logic [3:0] kOR             = 4'd9;
  localparam logic [3:0] kXOR            = 4'd10;
  localparam logic [3:0] kINPUTA_IS_ZERO = 4'd11;
endpackage

// alu_cmd_sequencer: command-side driver for the combinational 8-bit ALU.
// Accepts commands on cmd_valid/cmd_ready, holds a 4 x 8 register file, drives
// registered operands/opcode to the ALU during ISSUE, samples the result at the
// following edge and writes it back in WRITE. A command repeats up to 15 times.
// Ports:
//   CLK, RESET                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready        command handshake (ready only in IDLE)
//   cmd_op/rd/ra/rb/count      opcode, register indices, iteration count (0 -> 1)
//   ld_valid/ld_addr/ld_data   direct register load, honored only in IDLE
//   alu_op/alu_a/alu_b         registered ALU inputs (kCLEAR/0 outside ISSUE)
//   alu_out/alu_ovf            ALU result and zero-test flag
//   rsp_valid/rsp_data         one-cycle completion pulse and result
//   zero_flag                  last sampled kINPUTA_IS_ZERO result
//   dbg_addr/dbg_data          combinational register-file read port
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int WIDTH    = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [1:0]       cmd_rd,
  input  logic [1:0]       cmd_ra,
  input  logic [1:0]       cmd_rb,
  input  logic [3:0]       cmd_count,
  input  logic             ld_valid,
  input  logic [1:0]       ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_ovf,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             zero_flag,
  input  logic [1:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WRITE, DONE} state_t;

  state_t             state_reg, state_next;
  logic [3:0]         op_reg;
  logic [1:0]         rd_reg, ra_reg, rb_reg;
  logic [3:0]         remaining_reg;
  logic [WIDTH-1:0]   res_reg;
  logic               ovf_reg;
  logic               zero_flag_reg;
  logic               rsp_valid_reg;
  logic [WIDTH-1:0]   rsp_data_reg;
  logic [3:0]         alu_op_reg;
  logic [WIDTH-1:0]   alu_a_reg, alu_b_reg;
  logic [WIDTH-1:0]   rf_reg [NUM_REGS];

  logic               accept;
  logic               is_zero_op;
  logic               wr_en;
  logic [1:0]         wr_addr;
  logic [WIDTH-1:0]   wr_data;
  logic [NUM_REGS-1:0] rf_we;
  logic [1:0]         src_a, src_b;
  logic [WIDTH-1:0]   a_next, b_next;

  assign cmd_ready  = (state_reg == IDLE);
  assign accept     = cmd_valid && cmd_ready;
  assign is_zero_op = (op_reg == kINPUTA_IS_ZERO);

  // Single write port: loads only happen in IDLE and write-back only in WRITE,
  // so the two sources never collide.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = rd_reg;
    wr_data = res_reg;
    if (state_reg == IDLE && ld_valid) begin
      wr_en   = 1'b1;
      wr_addr = ld_addr;
      wr_data = ld_data;
    end else if (state_reg == WRITE && !is_zero_op) begin
      wr_en = 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_we
    assign rf_we[gi] = wr_en && (wr_addr == 2'(gi));
  end

  // Operand fetch forwards the write landing on the same edge: the direct load
  // when accepting from IDLE, the write-back when looping from WRITE (so a
  // command with rd == ra chains its own results).
  always_comb begin
    src_a  = (state_reg == IDLE) ? cmd_ra : ra_reg;
    src_b  = (state_reg == IDLE) ? cmd_rb : rb_reg;
    a_next = (wr_en && wr_addr == src_a) ? wr_data : rf_reg[src_a];
    b_next = (wr_en && wr_addr == src_b) ? wr_data : rf_reg[src_b];
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cmd_valid) state_next = ISSUE;
      ISSUE:   state_next = WRITE;
      WRITE:   state_next = (remaining_reg > 4'd1) ? ISSUE : DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      op_reg        <= kCLEAR;
      rd_reg        <= '0;
      ra_reg        <= '0;
      rb_reg        <= '0;
      remaining_reg <= '0;
      res_reg       <= '0;
      ovf_reg       <= 1'b0;
      zero_flag_reg <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      alu_op_reg    <= kCLEAR;
      alu_a_reg     <= '0;
      alu_b_reg     <= '0;
    end else begin
      // ALU inputs are quiet unless the next cycle is ISSUE.
      alu_op_reg    <= kCLEAR;
      alu_a_reg     <= '0;
      alu_b_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      if (state_next == ISSUE) begin
        alu_op_reg <= (state_reg == IDLE) ? cmd_op : op_reg;
        alu_a_reg  <= a_next;
        alu_b_reg  <= b_next;
      end
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_reg        <= cmd_op;
            rd_reg        <= cmd_rd;
            ra_reg        <= cmd_ra;
            rb_reg        <= cmd_rb;
            remaining_reg <= (cmd_count == 4'd0) ? 4'd1 : cmd_count;
          end
        end
        ISSUE: begin
          res_reg <= alu_out;
          if (is_zero_op) ovf_reg <= alu_ovf;
        end
        WRITE: begin
          remaining_reg <= remaining_reg - 4'd1;
          if (is_zero_op) zero_flag_reg <= ovf_reg;
          if (remaining_reg <= 4'd1) begin
            rsp_valid_reg <= 1'b1;
            rsp_data_reg  <= is_zero_op ? {{(WIDTH-1){1'b0}}, ovf_reg} : res_reg;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_REGS; i++) rf_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (rf_we[i]) rf_reg[i] <= wr_data;
      end
    end
  end

  assign alu_op    = alu_op_reg;
  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign zero_flag = zero_flag_reg;
  assign dbg_data  = rf_reg[dbg_addr];

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: table vectors, directed multi-cycle corner
// cases and randomized commands checked against a command-level model.
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;
  import alu_cmd_sequencer_pkg::*;

  logic       CLK, RESET;
  logic       cmd_valid, cmd_ready;
  logic [3:0] cmd_op, cmd_count;
  logic [1:0] cmd_rd, cmd_ra, cmd_rb;
  logic       ld_valid;
  logic [1:0] ld_addr;
  logic [7:0] ld_data;
  logic [3:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_out;
  logic       alu_ovf;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       zero_flag;
  logic [1:0] dbg_addr;
  logic [7:0] dbg_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mregs [4];
  logic       mzf;

  alu_cmd_sequencer #(.NUM_REGS(4), .WIDTH(8)) dut (
    .CLK(CLK), .RESET(RESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .cmd_count(cmd_count),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .zero_flag(zero_flag),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  // Behaviour of the external ALU, also used by the command-level model.
  function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    case (op)
      kADD:         return a + b;
      kSUB:         return a - b;
      kINC_INPUTA:  return a + 8'd1;
      kDEC_INPUTA:  return a - 8'd1;
      kSHIFT_LEFT:  return a << 1;
      kSHIFT_RIGHT: return a >> 1;
      kPASS_INPUTA: return a;
      kAND:         return a & b;
      kOR:          return a | b;
      kXOR:         return a ^ b;
      default:      return 8'h00;
    endcase
  endfunction

  assign alu_out = alu_fn(alu_op, alu_a, alu_b);
  assign alu_ovf = (alu_op == kINPUTA_IS_ZERO) && (alu_a == 8'h00);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      check($sformatf("%s_reg%0d", tag, i), dbg_data, mregs[i]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
    mzf = 1'b0;
  endtask

  // Called at a negedge in IDLE; returns at the following negedge.
  task automatic do_load(input logic [1:0] a, input logic [7:0] d);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    @(negedge CLK);
    ld_valid = 1'b0;
    mregs[a] = d;
    $display("load   reg%0d <= %02h", a, d);
  endtask

  // ldmode: 0 none, 1 load on the accept edge (bypass), 2 load held while busy (ignored).
  task automatic run_cmd(input string tag, input logic [3:0] op, input logic [1:0] rd,
                         input logic [1:0] ra, input logic [1:0] rb, input logic [3:0] cnt,
                         input int ldmode, input logic [1:0] la, input logic [7:0] ldd,
                         output logic [7:0] got_data);
    int n, first_rsp, idx;
    bit ready_bad, iface_bad;
    logic [7:0] ea[$], eb[$];
    logic [7:0] r, exp_data;
    n = (cnt == 4'd0) ? 1 : int'(cnt);
    if (ldmode == 1) mregs[la] = ldd;
    r = 8'h00;
    for (int i = 0; i < n; i++) begin
      ea.push_back(mregs[ra]);
      eb.push_back(mregs[rb]);
      r = alu_fn(op, mregs[ra], mregs[rb]);
      if (op == kINPUTA_IS_ZERO) mzf = (mregs[ra] == 8'h00);
      else mregs[rd] = r;
    end
    exp_data = (op == kINPUTA_IS_ZERO) ? {7'b0, mzf} : r;

    check({tag, "_ready_idle"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_count = cnt;
    ld_valid = (ldmode == 1); ld_addr = la; ld_data = ldd;
    @(negedge CLK);
    // Fields may change after acceptance; scramble them to prove they were latched.
    cmd_valid = 1'b0;
    cmd_op = 4'($urandom); cmd_rd = 2'($urandom); cmd_ra = 2'($urandom);
    cmd_rb = 2'($urandom); cmd_count = 4'($urandom);
    ld_valid = (ldmode == 2); ld_addr = la; ld_data = ldd;
    first_rsp = 0; ready_bad = 0; iface_bad = 0; got_data = 8'h00;
    for (int k = 1; k <= 2*n + 2; k++) begin
      if (k == 2*n + 2) ld_valid = 1'b0;
      if (k <= 2*n + 1 && cmd_ready) ready_bad = 1;
      if (rsp_valid && first_rsp == 0) begin
        first_rsp = k;
        got_data  = rsp_data;
      end
      if (k % 2 == 1 && k < 2*n + 1) begin
        idx = k / 2;
        if (alu_op !== op || alu_a !== ea[idx] || alu_b !== eb[idx]) iface_bad = 1;
      end else if (alu_op !== kCLEAR || alu_a !== 8'h00 || alu_b !== 8'h00) begin
        iface_bad = 1;
      end
      if (k < 2*n + 2) @(negedge CLK);
    end
    check({tag, "_latency"}, first_rsp, 2*n + 1);
    check({tag, "_rsp_data"}, got_data, exp_data);
    check({tag, "_ready_busy"}, ready_bad, 0);
    check({tag, "_alu_iface"}, iface_bad, 0);
    check({tag, "_ready_back"}, cmd_ready, 1);
    check({tag, "_zero_flag"}, zero_flag, mzf);
    check_regs(tag);
    $display("cmd %s op=%0d rd=%0d ra=%0d rb=%0d cnt=%0d ld=%0d -> rsp %02h (exp %02h) at cycle %0d",
             tag, op, rd, ra, rb, cnt, ldmode, got_data, exp_data, first_rsp);
  endtask

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] cnt;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [13];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] got;
    bit seen_rsp;
    vecs[0]  = '{kADD,            8'h05, 8'h03, 4'd0, 8'h08};
    vecs[1]  = '{kSUB,            8'h00, 8'h01, 4'd1, 8'hFF};
    vecs[2]  = '{kINC_INPUTA,     8'hFF, 8'h00, 4'd1, 8'h00};
    vecs[3]  = '{kDEC_INPUTA,     8'h00, 8'h00, 4'd1, 8'hFF};
    vecs[4]  = '{kSHIFT_LEFT,     8'h81, 8'h00, 4'd1, 8'h02};
    vecs[5]  = '{kSHIFT_RIGHT,    8'h81, 8'h00, 4'd1, 8'h40};
    vecs[6]  = '{kPASS_INPUTA,    8'hAA, 8'h55, 4'd1, 8'hAA};
    vecs[7]  = '{kAND,            8'hF0, 8'h3C, 4'd1, 8'h30};
    vecs[8]  = '{kOR,             8'hF0, 8'h0F, 4'd1, 8'hFF};
    vecs[9]  = '{kXOR,            8'hFF, 8'h0F, 4'd1, 8'hF0};
    vecs[10] = '{kINPUTA_IS_ZERO, 8'h00, 8'h00, 4'd1, 8'h01};
    vecs[11] = '{4'd13,           8'h12, 8'h34, 4'd1, 8'h00};
    vecs[12] = '{kADD,            8'h05, 8'h03, 4'd3, 8'h08};

    RESET = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_ra = '0; cmd_rb = '0;
    cmd_count = '0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    model_reset();
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    check("reset_ready", cmd_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_alu_op", alu_op, kCLEAR);
    check("reset_alu_a", alu_a, 0);
    check("reset_alu_b", alu_b, 0);
    check("reset_zero_flag", zero_flag, 0);
    check_regs("reset");
    @(negedge CLK);

    // Table vectors: reg0 = A, reg1 = B, rd = 2.
    for (int i = 0; i < 13; i++) begin
      do_load(2'd0, vecs[i].a);
      do_load(2'd1, vecs[i].b);
      run_cmd($sformatf("vec%0d", i), vecs[i].op, 2'd2, 2'd0, 2'd1, vecs[i].cnt, 0, 2'd0, 8'h00, got);
      check($sformatf("vec%0d_table", i), got, vecs[i].exp);
    end

    // Shift loop chaining through rd == ra: alu_a sequence 01, 02, 04.
    do_load(2'd0, 8'h01);
    run_cmd("shl_loop", kSHIFT_LEFT, 2'd0, 2'd0, 2'd0, 4'd3, 0, 2'd0, 8'h00, got);
    check("shl_loop_result", got, 8'h08);

    // Zero test: set then clear the flag.
    do_load(2'd3, 8'h00);
    run_cmd("iszero_1", kINPUTA_IS_ZERO, 2'd3, 2'd3, 2'd0, 4'd1, 0, 2'd0, 8'h00, got);
    check("iszero_1_flag", zero_flag, 1);
    do_load(2'd3, 8'h10);
    run_cmd("iszero_0", kINPUTA_IS_ZERO, 2'd3, 2'd3, 2'd0, 4'd1, 0, 2'd0, 8'h00, got);
    check("iszero_0_flag", zero_flag, 0);
    check("iszero_0_data", got, 8'h00);

    // Same-edge load bypass, then a load held during a busy command.
    run_cmd("bypass", kPASS_INPUTA, 2'd2, 2'd1, 2'd0, 4'd1, 1, 2'd1, 8'hAA, got);
    dbg_addr = 2'd2; #1;
    check("bypass_reg2", dbg_data, 8'hAA);
    run_cmd("ld_busy", kPASS_INPUTA, 2'd0, 2'd1, 2'd1, 4'd2, 2, 2'd3, 8'h5A, got);
    dbg_addr = 2'd3; #1;
    check("ld_busy_reg3", dbg_data, 8'h10);

    // Randomized commands.
    for (int t = 0; t < 40; t++) begin
      int nl;
      nl = int'($urandom_range(0, 2));
      for (int j = 0; j < nl; j++) do_load(2'($urandom), 8'($urandom));
      run_cmd($sformatf("rnd%0d", t), 4'($urandom_range(0, 15)), 2'($urandom), 2'($urandom),
              2'($urandom), 4'($urandom_range(0, 5)), int'($urandom_range(0, 2)),
              2'($urandom), 8'($urandom), got);
    end

    // RESET in WRITE of a count-5 command, with zero_flag set beforehand.
    do_load(2'd3, 8'h00);
    run_cmd("pre_rst", kINPUTA_IS_ZERO, 2'd0, 2'd3, 2'd0, 4'd1, 0, 2'd0, 8'h00, got);
    do_load(2'd0, 8'h07);
    do_load(2'd1, 8'h01);
    cmd_valid = 1'b1; cmd_op = kADD; cmd_rd = 2'd2; cmd_ra = 2'd0; cmd_rb = 2'd1; cmd_count = 4'd5;
    @(negedge CLK);                       // cycle 1: ISSUE
    cmd_valid = 1'b0;
    @(negedge CLK);                       // cycle 2: WRITE
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
    check("rst_ready", cmd_ready, 1);
    check("rst_alu_op", alu_op, kCLEAR);
    check("rst_alu_a", alu_a, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_zero_flag", zero_flag, 0);
    check_regs("rst");
    seen_rsp = 0;
    for (int k = 0; k < 12; k++) begin
      if (rsp_valid) seen_rsp = 1;
      @(negedge CLK);
    end
    check("rst_no_rsp", seen_rsp, 0);
    $display("reset mid-command: regs cleared, no response observed=%0d", seen_rsp);
    do_load(2'd1, 8'h22);
    run_cmd("post_rst", kADD, 2'd2, 2'd1, 2'd1, 4'd1, 0, 2'd0, 8'h00, got);
    check("post_rst_data", got, 8'h44);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
